l1_veri_yolu_kopru: RTL and testbench
=====================================

# l1_veri_yolu_kopru

Bus controller between the L1 cache and the word-wide main-memory port. It accepts one L1-block-wide read or write request, splits it into `L1_BLOK_BIT/VERI_BIT` word beats on the memory port, and returns an assembled block for reads. It sits between the L1 cache and the memory (or `memory_model` in simulation).

## Interface
- `ADRES_BIT`, 32, address width
- `VERI_BIT`, 32, memory word width
- `L1_BLOK_BIT`, 128, L1 block width; must be an integer multiple of `VERI_BIT`; beat count N = `L1_BLOK_BIT/VERI_BIT` (4)
- `clk_i`  in  1  single clock, rising edge
- `rst_i`  in  1  asynchronous, active-high reset
- `mem_istek_adres_o`  out  ADRES_BIT  beat address
- `mem_istek_veri_o`  out  VERI_BIT  write beat data
- `mem_istek_yaz_o`  out  1  1 = write beat, 0 = read beat
- `mem_istek_gecerli_o` / `mem_istek_hazir_i`  out/in  1  memory request handshake
- `mem_veri_i`  in  VERI_BIT  read data
- `mem_veri_gecerli_i` / `mem_veri_hazir_o`  in/out  1  memory response handshake
- `l1_istek_adres_i`  in  ADRES_BIT  block address, block-aligned
- `l1_istek_veri_i`  in  L1_BLOK_BIT  write block
- `l1_istek_yaz_i`  in  1  1 = write, 0 = read
- `l1_istek_gecerli_i` / `l1_istek_hazir_o`  in/out  1  L1 request handshake
- `l1_veri_o`  out  L1_BLOK_BIT  read block
- `l1_veri_gecerli_o` / `l1_veri_hazir_i`  out/in  1  L1 response handshake

## Operation
- A handshake occurs on any edge where valid and ready are both high.
- FSM states:
  - BOSTA: `l1_istek_hazir_o`=1. On L1 handshake, latch address, data and yaz, and clear beat counter k.
    - Write: go to YAZ.
    - Read: go to OKU_ISTEK.
  - YAZ: drive `mem_istek_gecerli_o`=1, `yaz_o`=1, address = base + k·(VERI_BIT/8), data = block[k·VERI_BIT +: VERI_BIT]. On memory handshake, k++. After beat N-1 handshakes, go to BOSTA. Writes produce no L1 response.
  - OKU_ISTEK: drive gecerli=1, `yaz_o`=0, address as above. On handshake, go to OKU_VERI.
  - OKU_VERI: `mem_veri_hazir_o`=1. On response handshake, store `mem_veri_i` into buffer[k·VERI_BIT +: VERI_BIT] and k++. If it was the last beat, go to YANIT; otherwise go to OKU_ISTEK.
  - YANIT: `l1_veri_gecerli_o`=1 and `l1_veri_o`=buffer, both held stable until `l1_veri_hazir_i`. On handshake, go to BOSTA.
- Beat order is little-endian: the lowest address maps to the lowest bits.
- `mem_veri_hazir_o` is 0 outside OKU_VERI. Any `mem_veri_gecerli_i` pulses arriving outside OKU_VERI (e.g. write acknowledgements) are ignored.
- Only one outstanding block and one outstanding memory beat at any time.
- Reset:
  - FSM goes to BOSTA and k=0.
  - All `mem_*_o` outputs, `l1_veri_gecerli_o` and `l1_veri_o` go to 0.
  - `l1_istek_hazir_o` goes to 1.
  - Reset mid-transfer abandons the transfer; no partial response is issued.

## Timing
- Request handshake at edge 0 gives BOSTA→YAZ/OKU_ISTEK at edge 0. The first beat is driven in cycle 1.
- Write with `mem_istek_hazir_i` tied high: one beat per cycle, cycles 1..N. `l1_istek_hazir_o` returns high in cycle N+1.
- Read with 1-cycle memory latency: 2 cycles per beat. `l1_veri_gecerli_o` rises in cycle 2N+1 (cycle 9 for N=4).
- `mem_istek_hazir_i` low stalls the current beat; address, data and yaz are held stable.
- `l1_veri_hazir_i` low holds YANIT indefinitely.
- New L1 requests are accepted only in BOSTA; there is no combinational path from the `l1_istek_*` inputs to `l1_istek_hazir_o`.

## Structure
- Shared package/header (`sabitler.vh`): ADRES_BIT, VERI_BIT, L1_BLOK_BIT, L1_BLOK_BYTE, BELLEK_BASLANGIC, BELLEK_BOYUT, HIGH/LOW, FSM state encodings.
- Single module; no sub-module needed. `memory_model` is a simulation-only memory (synchronous, 1-cycle read) and is not part of the synthesizable block.

## Test plan
- Write blocks i=0..3 at BELLEK_BASLANGIC+16·i, each filled with byte i (e.g. 0x01010101…) -> exactly 4 write beats per block at +0/+4/+8/+12; no `l1_veri_gecerli_o`.
- Read back the same 4 blocks -> `l1_veri_o` = 16× byte i, first valid 9 cycles after the request handshake.
- Write a block with distinct words 0x33333333_22222222_11111111_00000000, then read it back -> the word at +0 is 0x00000000, and the read returns the identical block.
- Hold `l1_veri_hazir_i` low 5 cycles during YANIT -> data and valid held stable; `l1_istek_hazir_o`=0 until the handshake.
- Deassert `mem_istek_hazir_i` for 3 cycles mid-write -> beat held; total beats still 4 with correct addresses.
- Assert `rst_i` during OKU_VERI -> outputs return to reset values immediately; a subsequent read returns the correct data.

Source files
------------

// File: rtl/l1_veri_yolu_kopru_pkg.sv
// rtl/l1_veri_yolu_kopru_pkg.sv - shared widths, memory map constants and FSM states for the L1/memory bridge
package l1_veri_yolu_kopru_pkg;

    localparam int ADRES_BIT    = 32;
    localparam int VERI_BIT     = 32;
    localparam int L1_BLOK_BIT  = 128;
    localparam int L1_BLOK_BYTE = L1_BLOK_BIT / 8;
    localparam int VERI_BYTE    = VERI_BIT / 8;
    localparam int BEAT_SAYISI  = L1_BLOK_BIT / VERI_BIT;
    localparam int BEAT_BIT     = (BEAT_SAYISI > 1) ? $clog2(BEAT_SAYISI) : 1;

    localparam logic [ADRES_BIT-1:0] BELLEK_BASLANGIC = 32'h8000_0000;
    localparam logic [ADRES_BIT-1:0] BELLEK_BOYUT     = 32'h0000_1000;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    typedef enum logic [2:0] {
        BOSTA     = 3'd0,
        YAZ       = 3'd1,
        OKU_ISTEK = 3'd2,
        OKU_VERI  = 3'd3,
        YANIT     = 3'd4
    } durum_e;

    typedef logic [BEAT_BIT-1:0] beat_t;

    // Beats are little-endian: beat k sits k words above the block base.
    function automatic logic [ADRES_BIT-1:0] beat_adresi(
        input logic [ADRES_BIT-1:0] taban,
        input beat_t                k
    );
        return taban + ADRES_BIT'(k) * ADRES_BIT'(VERI_BYTE);
    endfunction

endpackage

// File: rtl/l1_veri_yolu_kopru_if.sv
// rtl/l1_veri_yolu_kopru_if.sv - request/response bus used on both the L1 side (block wide) and memory side (word wide)
interface l1_veri_yolu_kopru_if
    import l1_veri_yolu_kopru_pkg::*;
#(
    parameter int ADRES_W = ADRES_BIT,
    parameter int VERI_W  = VERI_BIT
) ();

    logic [ADRES_W-1:0] istek_adres;
    logic [VERI_W-1:0]  istek_veri;
    logic               istek_yaz;
    logic               istek_gecerli;
    logic               istek_hazir;

    logic [VERI_W-1:0]  yanit_veri;
    logic               yanit_gecerli;
    logic               yanit_hazir;

    modport master (
        output istek_adres, istek_veri, istek_yaz, istek_gecerli, yanit_hazir,
        input  istek_hazir, yanit_veri, yanit_gecerli
    );

    modport slave (
        input  istek_adres, istek_veri, istek_yaz, istek_gecerli, yanit_hazir,
        output istek_hazir, yanit_veri, yanit_gecerli
    );

endinterface

// File: rtl/l1_veri_yolu_kopru.sv
// rtl/l1_veri_yolu_kopru.sv - splits one L1 block request into word beats on the memory port and assembles read blocks
module l1_veri_yolu_kopru
    import l1_veri_yolu_kopru_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    l1_veri_yolu_kopru_if.slave  l1_io,
    l1_veri_yolu_kopru_if.master mem_io
);

    durum_e                 durum_q, durum_d;
    beat_t                  k_q, k_d;
    logic [ADRES_BIT-1:0]   adres_q, adres_d;
    logic [L1_BLOK_BIT-1:0] blok_q, blok_d;
    logic [L1_BLOK_BIT-1:0] tampon_q, tampon_d;

    logic l1_istek_hs;
    logic mem_istek_hs;
    logic mem_yanit_hs;
    logic l1_yanit_hs;
    logic son_beat;

    // Handshakes are derived from state, never from our own outputs, so no input reaches istek_hazir combinationally.
    assign l1_istek_hs  = (durum_q == BOSTA) && l1_io.istek_gecerli;
    assign mem_istek_hs = ((durum_q == YAZ) || (durum_q == OKU_ISTEK)) && mem_io.istek_hazir;
    assign mem_yanit_hs = (durum_q == OKU_VERI) && mem_io.yanit_gecerli;
    assign l1_yanit_hs  = (durum_q == YANIT) && l1_io.yanit_hazir;
    assign son_beat     = (k_q == beat_t'(BEAT_SAYISI - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q  <= BOSTA;
            k_q      <= '0;
            adres_q  <= '0;
            blok_q   <= '0;
            tampon_q <= '0;
        end else begin
            durum_q  <= durum_d;
            k_q      <= k_d;
            adres_q  <= adres_d;
            blok_q   <= blok_d;
            tampon_q <= tampon_d;
        end
    end

    always_comb begin
        durum_d  = durum_q;
        k_d      = k_q;
        adres_d  = adres_q;
        blok_d   = blok_q;
        tampon_d = tampon_q;
        case (durum_q)
            BOSTA: begin
                if (l1_istek_hs) begin
                    adres_d = l1_io.istek_adres;
                    blok_d  = l1_io.istek_veri;
                    k_d     = '0;
                    durum_d = l1_io.istek_yaz ? YAZ : OKU_ISTEK;
                end
            end
            YAZ: begin
                if (mem_istek_hs) begin
                    k_d = k_q + 1'b1;
                    if (son_beat) begin
                        durum_d = BOSTA;
                    end
                end
            end
            OKU_ISTEK: begin
                if (mem_istek_hs) begin
                    durum_d = OKU_VERI;
                end
            end
            OKU_VERI: begin
                if (mem_yanit_hs) begin
                    tampon_d[int'(k_q)*VERI_BIT +: VERI_BIT] = mem_io.yanit_veri;
                    k_d     = k_q + 1'b1;
                    durum_d = son_beat ? YANIT : OKU_ISTEK;
                end
            end
            YANIT: begin
                if (l1_yanit_hs) begin
                    durum_d = BOSTA;
                end
            end
            default: durum_d = BOSTA;
        endcase
    end

    // Every output is gated by state, so reset (state forced to BOSTA) clears them without waiting for a clock.
    always_comb begin
        l1_io.istek_hazir    = LOW;
        l1_io.yanit_gecerli  = LOW;
        l1_io.yanit_veri     = '0;
        mem_io.istek_gecerli = LOW;
        mem_io.istek_yaz     = LOW;
        mem_io.istek_adres   = '0;
        mem_io.istek_veri    = '0;
        mem_io.yanit_hazir   = LOW;
        case (durum_q)
            BOSTA: begin
                l1_io.istek_hazir = HIGH;
            end
            YAZ: begin
                mem_io.istek_gecerli = HIGH;
                mem_io.istek_yaz     = HIGH;
                mem_io.istek_adres   = beat_adresi(adres_q, k_q);
                mem_io.istek_veri    = blok_q[int'(k_q)*VERI_BIT +: VERI_BIT];
            end
            OKU_ISTEK: begin
                mem_io.istek_gecerli = HIGH;
                mem_io.istek_adres   = beat_adresi(adres_q, k_q);
            end
            OKU_VERI: begin
                mem_io.yanit_hazir = HIGH;
            end
            YANIT: begin
                l1_io.yanit_gecerli = HIGH;
                l1_io.yanit_veri    = tampon_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l1_veri_yolu_kopru.sv
// tb/tb_l1_veri_yolu_kopru.sv - directed self-checking bench for l1_veri_yolu_kopru with a 1-cycle memory model
module tb_l1_veri_yolu_kopru;
    import l1_veri_yolu_kopru_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc;

    always #5 clk = ~clk;

    l1_veri_yolu_kopru_if #(.ADRES_W(ADRES_BIT), .VERI_W(L1_BLOK_BIT)) l1_bus ();
    l1_veri_yolu_kopru_if #(.ADRES_W(ADRES_BIT), .VERI_W(VERI_BIT))    mem_bus ();

    l1_veri_yolu_kopru dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .l1_io  (l1_bus),
        .mem_io (mem_bus)
    );

    // Memory model: 64 words from BELLEK_BASLANGIC, read data one cycle after the request handshake,
    // write requests answered by a one-cycle junk acknowledgement pulse.
    logic [31:0] mem_arr [0:63];
    logic [31:0] wr_log  [0:63];
    int          wr_cnt  = 0;
    int          vld_cnt = 0;
    bit          bellek_hazir = 1'b0;
    bit          oku_bekliyor = 1'b0;

    always @(posedge clk) begin
        if (!bellek_hazir) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= 32'hA5A5_A5A5;
            bellek_hazir <= 1'b1;
        end
        if (l1_bus.yanit_gecerli) vld_cnt <= vld_cnt + 1;
        if (rst) begin
            mem_bus.yanit_gecerli <= 1'b0;
            mem_bus.yanit_veri    <= '0;
            oku_bekliyor          <= 1'b0;
        end else begin
            if (!(mem_bus.yanit_gecerli && !mem_bus.yanit_hazir && oku_bekliyor))
                mem_bus.yanit_gecerli <= 1'b0;
            if (mem_bus.istek_gecerli && mem_bus.istek_hazir) begin
                mem_bus.yanit_gecerli <= 1'b1;
                if (mem_bus.istek_yaz) begin
                    mem_arr[mem_bus.istek_adres[7:2]] <= mem_bus.istek_veri;
                    wr_log[wr_cnt[5:0]]              <= mem_bus.istek_adres;
                    wr_cnt                           <= wr_cnt + 1;
                    mem_bus.yanit_veri               <= 32'hDEAD_BEEF;
                    oku_bekliyor                     <= 1'b0;
                end else begin
                    mem_bus.yanit_veri <= mem_arr[mem_bus.istek_adres[7:2]];
                    oku_bekliyor       <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one L1 request and returns 1 time unit after the handshake edge (start of cycle 1).
    task automatic istek(input logic [31:0] a, input logic [127:0] d, input logic y);
        int n;
        @(negedge clk);
        l1_bus.istek_adres   = a;
        l1_bus.istek_veri    = d;
        l1_bus.istek_yaz     = y;
        l1_bus.istek_gecerli = 1'b1;
        n = 0;
        while (!l1_bus.istek_hazir && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("istek_kabul", 128'(l1_bus.istek_hazir), 128'(1));
        @(posedge clk);
        #1;
        l1_bus.istek_gecerli = 1'b0;
        cyc = 1;
    endtask

    task automatic yaz_blok(input string tag, input logic [31:0] a, input logic [127:0] d,
                            input bit stall, input int exp_lat);
        int s, v;
        s = wr_cnt;
        v = vld_cnt;
        istek(a, d, 1'b1);
        if (stall) begin
            @(posedge clk); #1; cyc++;
            mem_bus.istek_hazir = 1'b0;
            for (int t = 0; t < 3; t++) begin
                @(posedge clk); #1; cyc++;
                chk({tag, "_stall_adres"}, 128'(mem_bus.istek_adres), 128'(a + 32'd4));
                chk({tag, "_stall_veri"}, 128'(mem_bus.istek_veri), 128'(d[63:32]));
                chk({tag, "_stall_gecerli_yaz"}, 128'({mem_bus.istek_gecerli, mem_bus.istek_yaz}), 128'(2'b11));
            end
            mem_bus.istek_hazir = 1'b1;
        end
        while (!l1_bus.istek_hazir && cyc < 60) begin
            @(posedge clk); #1; cyc++;
        end
        chk({tag, "_sure"}, 128'(cyc), 128'(exp_lat));
        chk({tag, "_beat_sayisi"}, 128'(wr_cnt - s), 128'(4));
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("%s_adres%0d", tag, j), 128'(wr_log[6'(s + j)]), 128'(a + 32'(4 * j)));
            chk($sformatf("%s_bellek%0d", tag, j), 128'(mem_arr[6'(a[7:2]) + 6'(j)]), 128'(d[32*j +: 32]));
        end
        chk({tag, "_l1_yanit_yok"}, 128'(vld_cnt - v), 128'(0));
    endtask

    task automatic oku_blok(input string tag, input logic [31:0] a, input logic [127:0] exp,
                            input int exp_lat);
        istek(a, '0, 1'b0);
        while (!l1_bus.yanit_gecerli && cyc < 60) begin
            @(posedge clk); #1; cyc++;
        end
        chk({tag, "_gecikme"}, 128'(cyc), 128'(exp_lat));
        chk({tag, "_veri"}, l1_bus.yanit_veri, exp);
        @(posedge clk); #1;
        chk({tag, "_yanit_bitti"}, 128'({l1_bus.yanit_gecerli, l1_bus.istek_hazir}), 128'(2'b01));
    endtask

    task automatic reset_cikislari(input string tag);
        chk({tag, "_l1_istek_hazir"}, 128'(l1_bus.istek_hazir), 128'(1));
        chk({tag, "_l1_yanit_gecerli"}, 128'(l1_bus.yanit_gecerli), 128'(0));
        chk({tag, "_l1_veri"}, l1_bus.yanit_veri, 128'(0));
        chk({tag, "_mem_gecerli"}, 128'(mem_bus.istek_gecerli), 128'(0));
        chk({tag, "_mem_adres"}, 128'(mem_bus.istek_adres), 128'(0));
        chk({tag, "_mem_veri"}, 128'(mem_bus.istek_veri), 128'(0));
        chk({tag, "_mem_yaz"}, 128'(mem_bus.istek_yaz), 128'(0));
        chk({tag, "_mem_yanit_hazir"}, 128'(mem_bus.yanit_hazir), 128'(0));
    endtask

    initial begin
        logic [127:0] blk;
        logic [127:0] tutulan;
        int           v;

        l1_bus.istek_adres   = '0;
        l1_bus.istek_veri    = '0;
        l1_bus.istek_yaz     = 1'b0;
        l1_bus.istek_gecerli = 1'b0;
        l1_bus.yanit_hazir   = 1'b1;
        mem_bus.istek_hazir  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        reset_cikislari("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            blk = {16{8'(i)}};
            yaz_blok($sformatf("yaz_blok%0d", i), 32'h8000_0000 + 32'(16 * i), blk, 1'b0, 5);
        end
        for (int i = 0; i < 4; i++) begin
            blk = {16{8'(i)}};
            oku_blok($sformatf("oku_blok%0d", i), 32'h8000_0000 + 32'(16 * i), blk, 9);
        end

        yaz_blok("yaz_farkli", 32'h8000_0040, 128'h33333333_22222222_11111111_00000000, 1'b0, 5);
        chk("farkli_kelime0", 128'(mem_arr[16]), 128'(32'h0000_0000));
        chk("farkli_kelime1", 128'(mem_arr[17]), 128'(32'h1111_1111));
        oku_blok("oku_farkli", 32'h8000_0040, 128'h33333333_22222222_11111111_00000000, 9);

        l1_bus.yanit_hazir = 1'b0;
        istek(32'h8000_0040, '0, 1'b0);
        while (!l1_bus.yanit_gecerli && cyc < 60) begin
            @(posedge clk); #1; cyc++;
        end
        chk("tut_gecikme", 128'(cyc), 128'(9));
        tutulan = l1_bus.yanit_veri;
        chk("tut_ilk_veri", tutulan, 128'h33333333_22222222_11111111_00000000);
        for (int t = 0; t < 5; t++) begin
            @(posedge clk); #1;
            chk($sformatf("tut_gecerli%0d", t), 128'(l1_bus.yanit_gecerli), 128'(1));
            chk($sformatf("tut_veri%0d", t), l1_bus.yanit_veri, 128'h33333333_22222222_11111111_00000000);
            chk($sformatf("tut_istek_hazir%0d", t), 128'(l1_bus.istek_hazir), 128'(0));
        end
        l1_bus.yanit_hazir = 1'b1;
        @(posedge clk); #1;
        chk("tut_bitti_gecerli", 128'(l1_bus.yanit_gecerli), 128'(0));
        chk("tut_bitti_istek_hazir", 128'(l1_bus.istek_hazir), 128'(1));

        yaz_blok("yaz_durdur", 32'h8000_0080, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b1, 8);

        v = vld_cnt;
        istek(32'h8000_0080, '0, 1'b0);
        @(posedge clk); #1;
        chk("rst_oku_veri_durumu", 128'(mem_bus.yanit_hazir), 128'(1));
        rst = 1'b1;
        #1;
        reset_cikislari("rst_ortada");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_kismi_yanit_yok", 128'(vld_cnt - v), 128'(0));
        oku_blok("rst_sonra_oku", 32'h8000_0080, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
